// File: rtl/mnist_result_argmax.sv
// Result stage of the MNIST systolic-array wrapper: streamed argmax with one-hot, 7-seg and ready outputs.
// Optional runner-up tracking and score margin output enabled by defining ARGMAX_MARGIN_EN.
module mnist_result_argmax #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_comp,
    input  logic                         score_valid,
    input  logic signed [DATA_WIDTH-1:0] score_data,
    input  logic                         score_last,
    output logic                         ready,
    output logic [NUM_CLASSES-1:0]       classes,
    output logic [7:0]                   hex_connect,
    output logic signed [DATA_WIDTH-1:0] max_score,
    output logic                         err,
    output logic signed [DATA_WIDTH-1:0] margin
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]             LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_start_q;
    logic [IDX_W-1:0]               r_index;
    logic signed [DATA_WIDTH-1:0]   r_best;
    logic [IDX_W-1:0]               r_best_idx;
    logic [NUM_CLASSES-1:0]         r_classes;
    logic [7:0]                     r_hex;
    logic signed [DATA_WIDTH-1:0]   r_max_score;
    logic                           r_err;

    logic                           w_start;
    logic                           w_take;
    logic                           w_replace;
    logic                           w_at_end;
    logic                           w_finish;
    logic                           w_err_nxt;
    logic signed [DATA_WIDTH-1:0]   w_fin_best;
    logic [IDX_W-1:0]               w_fin_idx;

    function automatic logic [7:0] f_seg(input logic [IDX_W-1:0] idx);
        case (int'(idx))
            0:       f_seg = 8'hC0;
            1:       f_seg = 8'hF9;
            2:       f_seg = 8'hA4;
            3:       f_seg = 8'hB0;
            4:       f_seg = 8'h99;
            5:       f_seg = 8'h92;
            6:       f_seg = 8'h82;
            7:       f_seg = 8'hF8;
            8:       f_seg = 8'h80;
            9:       f_seg = 8'h90;
            default: f_seg = 8'hFF;
        endcase
    endfunction

    // Falling edge of start_comp only: a start held low arms exactly once.
    assign w_start    = ~start_comp & r_start_q;
    assign w_take     = (r_state == S_ACC) & score_valid & ~w_start;
    assign w_replace  = w_take & (score_data > r_best);
    assign w_at_end   = (r_index == LAST_IDX);
    assign w_finish   = w_take & (score_last | w_at_end);
    assign w_err_nxt  = ~(score_last & w_at_end);
    assign w_fin_best = w_replace ? score_data : r_best;
    assign w_fin_idx  = w_replace ? r_index : r_best_idx;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_ACC;
            S_ACC: begin
                if (w_start)       w_state_nxt = S_ACC;
                else if (w_finish) w_state_nxt = S_DONE;
            end
            S_DONE:  if (w_start) w_state_nxt = S_ACC;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q   <= 1'b1;
            r_index     <= '0;
            r_best      <= MOST_NEG;
            r_best_idx  <= '0;
            r_classes   <= '0;
            r_hex       <= 8'hFF;
            r_max_score <= '0;
            r_err       <= 1'b0;
        end else begin
            r_start_q <= start_comp;
            if (w_start) begin
                r_index    <= '0;
                r_best     <= MOST_NEG;
                r_best_idx <= '0;
            end else if (w_take) begin
                r_index    <= r_index + IDX_W'(1);
                r_best     <= w_fin_best;
                r_best_idx <= w_fin_idx;
                if (w_finish) begin
                    r_classes   <= NUM_CLASSES'(1) << w_fin_idx;
                    r_hex       <= w_err_nxt ? 8'h86 : f_seg(w_fin_idx);
                    r_max_score <= w_fin_best;
                    r_err       <= w_err_nxt;
                end
            end
        end
    end

`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [DATA_WIDTH:0] MAX_POS = {2'b00, {(DATA_WIDTH-1){1'b1}}};

    logic signed [DATA_WIDTH-1:0] r_second;
    logic signed [DATA_WIDTH-1:0] r_margin;
    logic signed [DATA_WIDTH-1:0] w_fin_second;
    logic signed [DATA_WIDTH:0]   w_diff;

    // A displaced best becomes the runner-up; ties with the best land here too.
    always_comb begin
        w_fin_second = r_second;
        if (w_replace)
            w_fin_second = r_best;
        else if (w_take && (score_data > r_second))
            w_fin_second = score_data;
    end

    assign w_diff = {w_fin_best[DATA_WIDTH-1], w_fin_best} - {w_fin_second[DATA_WIDTH-1], w_fin_second};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_second <= MOST_NEG;
            r_margin <= '0;
        end else if (w_start) begin
            r_second <= MOST_NEG;
        end else if (w_take) begin
            r_second <= w_fin_second;
            if (w_finish)
                r_margin <= (w_diff > MAX_POS) ? MAX_POS[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
        end
    end

    assign margin = r_margin;
`else
    assign margin = '0;
`endif

    assign ready       = (r_state == S_DONE);
    assign classes     = r_classes;
    assign hex_connect = r_hex;
    assign max_score   = r_max_score;
    assign err         = r_err;

endmodule

// File: tb/tb_mnist_result_argmax.sv
// Self-checking bench for mnist_result_argmax: directed scenarios plus randomized images vs a queue-based argmax model.
module tb_mnist_result_argmax;
    localparam int DW  = 16;
    localparam int NC  = 10;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start_comp = 1'b1;
    logic                 score_valid = 1'b0;
    logic signed [DW-1:0] score_data = '0;
    logic                 score_last = 1'b0;
    logic                 ready;
    logic [NC-1:0]        classes;
    logic [7:0]           hex_connect;
    logic signed [DW-1:0] max_score;
    logic                 err;
    logic signed [DW-1:0] margin;

    mnist_result_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .start_comp(start_comp),
        .score_valid(score_valid), .score_data(score_data), .score_last(score_last),
        .ready(ready), .classes(classes), .hex_connect(hex_connect),
        .max_score(max_score), .err(err), .margin(margin)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          q[$];
    bit          m_active = 0;
    logic        exp_ready = 0;
    logic [NC-1:0] exp_cls = '0;
    logic [7:0]  exp_hex = 8'hFF;
    int          exp_max = 0;
    logic        exp_err = 0;
    int          exp_margin = 0;
    logic [7:0]  seg [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int          img [12];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_finalize(input bit last);
        int idx;
        int ru;
        int diff;
        idx = 0;
        foreach (q[i]) if (q[i] > q[idx]) idx = i;
        ru = -32768;
        foreach (q[i]) if (i != idx && q[i] > ru) ru = q[i];
        diff = q[idx] - ru;
        exp_ready  = 1;
        exp_cls    = NC'(1) << idx;
        exp_err    = !(last && q.size() == NC);
        exp_hex    = exp_err ? 8'h86 : seg[idx];
        exp_max    = q[idx];
        exp_margin = (diff > 32767) ? 32767 : diff;
        m_active   = 0;
    endtask

    task automatic model_feed(input int s, input bit last);
        if (!m_active) return;
        q.push_back(s);
        if (last || q.size() == NC) model_finalize(last);
    endtask

    task automatic model_start();
        q.delete();
        m_active  = 1;
        exp_ready = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0;
        exp_ready = 0; exp_cls = '0; exp_hex = 8'hFF;
        exp_max = 0; exp_err = 0; exp_margin = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        cyc();
        reset = 1'b0;
    endtask

    task automatic start();
        start_comp = 1'b0;
        model_start();
        cyc();
        start_comp = 1'b1;
        chk("ready_after_start", {31'b0, ready}, {31'b0, exp_ready});
    endtask

    task automatic send(input int s, input bit last, input int gaps);
        score_valid = 1'b1;
        score_data  = DW'(s);
        score_last  = last;
        model_feed(s, last);
        cyc();
        score_valid = 1'b0;
        score_last  = $urandom_range(0, 1) == 1;
        score_data  = DW'($urandom);
        chk("ready", {31'b0, ready}, {31'b0, exp_ready});
        repeat (gaps) begin
            cyc();
            chk("ready_gap", {31'b0, ready}, {31'b0, exp_ready});
        end
        score_last = 1'b0;
    endtask

    // sends img[0..n-1]; score_last on position last_at (-1: never)
    task automatic stream(input int n, input int last_at, input int gaps);
        for (int i = 0; i < n; i++) send(img[i], i == last_at, gaps);
    endtask

    task automatic check_all(input string tag);
        int em;
`ifdef ARGMAX_MARGIN_EN
        em = exp_margin;
`else
        em = 0;
`endif
        chk({tag, ".ready"},  {31'b0, ready}, {31'b0, exp_ready});
        chk({tag, ".classes"}, 32'(classes), 32'(exp_cls));
        chk({tag, ".hex"},    32'(hex_connect), 32'(exp_hex));
        chk({tag, ".max"},    32'(max_score) & 32'hFFFF, exp_max & 32'hFFFF);
        chk({tag, ".err"},    {31'b0, err}, {31'b0, exp_err});
        chk({tag, ".margin"}, 32'(margin) & 32'hFFFF, em & 32'hFFFF);
    endtask

    task automatic set_img(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        img[0] = a0; img[1] = a1; img[2] = a2; img[3] = a3; img[4] = a4;
        img[5] = a5; img[6] = a6; img[7] = a7; img[8] = a8; img[9] = a9;
    endtask

    initial begin
        logic signed [DW-1:0] r16;
        int mode;
        int n;
        int last_at;

        // reset state
        do_reset();
        cyc();
        check_all("reset");

        // basic image, winner class 2
        set_img(5, -3, 100, 7, 0, 2, 9, 1, 4, 8);
        start();
        stream(10, 9, 0);
        check_all("basic");
        chk("basic.classes_const", 32'(classes), 32'h004);
        chk("basic.hex_const", 32'(hex_connect), 32'hA4);

        // scores arriving in DONE are ignored
        send(30000, 1'b1, 0);
        send(-5, 1'b0, 1);
        check_all("done_hold");

        // tie keeps lower index
        set_img(0, 0, 0, 50, 50, 0, 0, 0, 0, 0);
        start();
        stream(10, 9, 0);
        check_all("tie");

        // all negative with two-cycle gaps
        set_img(-10, -9, -8, -7, -6, -5, -4, -3, -2, -1);
        start();
        stream(10, 9, 2);
        check_all("neg_gaps");
        chk("neg.hex_const", 32'(hex_connect), 32'h90);

        // short stream, then a clean full one
        set_img(3, 1, 4, 1, 5, 9, 2, 6, 5, 3);
        start();
        stream(6, 5, 0);
        check_all("short");
        start();
        stream(10, 9, 0);
        check_all("after_short");

        // missing score_last: closes at the tenth score, extra ignored
        set_img(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        img[10] = 500; img[11] = 600;
        start();
        stream(12, -1, 0);
        check_all("no_last");

        // start held low for several cycles arms once
        set_img(-1, 40, 2, 3, 4, 5, 6, 7, 8, 9);
        start_comp = 1'b0;
        model_start();
        cyc();
        for (int i = 0; i < 3; i++) send(img[i], 1'b0, 0);
        start_comp = 1'b1;
        for (int i = 3; i < 10; i++) send(img[i], i == 9, 0);
        check_all("start_held");

        // abort mid-image, then full image with winner 7
        set_img(900, 800, 700, 600, 0, 0, 0, 0, 0, 0);
        start();
        stream(4, -1, 0);
        set_img(1, 2, 3, 4, 5, 6, 7, 77, 8, 9);
        start();
        stream(10, 9, 0);
        check_all("abort");
        chk("abort.classes_const", 32'(classes), 32'h080);

        // reset mid-ACC, then a stream without start
        start();
        stream(3, -1, 0);
        do_reset();
        check_all("reset_mid");
        set_img(9, 8, 7, 6, 5, 4, 3, 2, 1, 0);
        stream(10, 9, 0);
        check_all("no_start");

        // randomized images
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 4);
            for (int i = 0; i < 12; i++) begin
                if (it % 3 == 0) img[i] = int'($urandom_range(0, 6)) - 3;
                else begin
                    r16 = DW'($urandom);
                    img[i] = r16;
                end
            end
            if (mode <= 2)      begin n = 10; last_at = 9; end
            else if (mode == 3) begin n = $urandom_range(1, 9); last_at = n - 1; end
            else                begin n = 12; last_at = -1; end
            start();
            stream(n, last_at, $urandom_range(0, 1));
            check_all("rand");
            if (it % 7 == 6) begin
                do_reset();
                check_all("rand_reset");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
